// File: rtl/fifo_dispatcher.sv
// Pops entries from a FIFO and dispatches each to one of two masters by its src bit.
// Mode-00 entries are discarded and counted; per-channel burst tracking pulses cmplt.
module fifo_dispatcher #(
  parameter int DW = 32,
  parameter int EW = DW + 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fifo_empty,
  output logic          fifo_rd_en,
  input  logic [EW-1:0] fifo_rdata,
  output logic [DW-1:0] mstr0_data,
  output logic [DW-1:0] mstr1_data,
  output logic [1:0]    mstr0_mode,
  output logic [1:0]    mstr1_mode,
  output logic          mstr0_valid,
  output logic          mstr1_valid,
  input  logic          mstr0_ready,
  input  logic          mstr1_ready,
  output logic          mstr0_cmplt,
  output logic          mstr1_cmplt,
  output logic [7:0]    drop_cnt
);

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, SEND} state_t;

  typedef struct packed {
    logic          src;
    logic [1:0]    mode;
    logic [7:0]    pv;
    logic [DW-1:0] data;
  } entry_t;

  state_t state, state_nx;
  entry_t entry, in_e;
  logic [1:0] valid, ready, accept, cmplt;

  assign in_e   = fifo_rdata;
  assign ready  = {mstr1_ready, mstr0_ready};
  assign accept = valid & ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    fifo_rd_en = 1'b0;
    valid      = 2'b00;
    case (state)
      IDLE:  if (!fifo_empty) state_nx = FETCH;
      FETCH: begin
        fifo_rd_en = 1'b1;
        state_nx   = LOAD;
      end
      LOAD:  state_nx = (in_e.mode == 2'b00) ? IDLE : SEND;
      SEND: begin
        valid[entry.src] = 1'b1;
        // ready only gates the transition, never valid itself
        if (|(valid & ready)) state_nx = fifo_empty ? IDLE : FETCH;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entry    <= '0;
      drop_cnt <= '0;
    end else if (state == LOAD) begin
      entry <= in_e;
      if (in_e.mode == 2'b00 && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  for (genvar n = 0; n < 2; n++) begin : g_ch
    logic [7:0] cnt, len, len_eff;
    logic       cmplt_q;

    // a burst's length is fixed by its first beat; proc_val 0 means a single beat
    always_comb len_eff = (cnt == 8'd0) ? ((entry.pv == 8'd0) ? 8'd1 : entry.pv) : len;

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt     <= '0;
        len     <= '0;
        cmplt_q <= 1'b0;
      end else begin
        cmplt_q <= 1'b0;
        if (accept[n]) begin
          if (cnt == 8'd0) len <= len_eff;
          if (cnt + 8'd1 == len_eff) begin
            cmplt_q <= 1'b1;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
      end
    end

    assign cmplt[n] = cmplt_q;
  end

  assign mstr0_valid = valid[0];
  assign mstr1_valid = valid[1];
  assign mstr0_data  = valid[0] ? entry.data : '0;
  assign mstr1_data  = valid[1] ? entry.data : '0;
  assign mstr0_mode  = valid[0] ? entry.mode : 2'b00;
  assign mstr1_mode  = valid[1] ? entry.mode : 2'b00;
  assign mstr0_cmplt = cmplt[0];
  assign mstr1_cmplt = cmplt[1];

endmodule

// File: tb/tb_fifo_dispatcher.sv
// Bench for fifo_dispatcher: queue-based FIFO model plus a per-channel beat/burst
// reference built from entry order, directed scenarios and a randomized run.
module tb_fifo_dispatcher;
  localparam int DW = 32;
  localparam int EW = DW + 11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_empty, fifo_rd_en;
  logic [EW-1:0] fifo_rdata = '0;
  logic [DW-1:0] mstr0_data, mstr1_data;
  logic [1:0]    mstr0_mode, mstr1_mode;
  logic          mstr0_valid, mstr1_valid, mstr0_cmplt, mstr1_cmplt;
  logic          rdy0 = 1'b0, rdy1 = 1'b0;
  logic [7:0]    drop_cnt;

  always #5 clk = ~clk;

  fifo_dispatcher #(.DW(DW), .EW(EW)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_rdata(fifo_rdata),
    .mstr0_data(mstr0_data), .mstr1_data(mstr1_data),
    .mstr0_mode(mstr0_mode), .mstr1_mode(mstr1_mode),
    .mstr0_valid(mstr0_valid), .mstr1_valid(mstr1_valid),
    .mstr0_ready(rdy0), .mstr1_ready(rdy1),
    .mstr0_cmplt(mstr0_cmplt), .mstr1_cmplt(mstr1_cmplt),
    .drop_cnt(drop_cnt)
  );

  // FIFO model: data appears the cycle after a pop request
  logic [EW-1:0] mem [0:2047];
  int wp = 0;
  int rp = 0;
  assign fifo_empty = (wp == rp);
  always @(posedge clk) begin
    if (fifo_rd_en === 1'b1) begin
      fifo_rdata <= mem[rp];
      rp <= rp + 1;
    end
  end

  typedef struct { logic [1:0] mode; logic [31:0] data; bit cm; } beat_t;
  beat_t expq0[$];
  beat_t expq1[$];
  int mcnt[2];
  int mlen[2];
  int exp_drops = 0;
  int n_chk = 0;
  int n_pass = 0;

  // push an entry and derive the beats/completions it should cause
  task automatic push(input bit s, input logic [1:0] m, input logic [7:0] pv, input logic [31:0] d);
    beat_t b;
    mem[wp] = {s, m, pv, d};
    wp++;
    if (m == 2'b00) exp_drops++;
    else begin
      if (mcnt[s] == 0) mlen[s] = (pv == 0) ? 1 : int'(pv);
      mcnt[s]++;
      b.mode = m; b.data = d; b.cm = (mcnt[s] == mlen[s]);
      if (b.cm) mcnt[s] = 0;
      if (s) expq1.push_back(b); else expq0.push_back(b);
    end
  endtask

  task automatic model_clear();
    expq0.delete();
    expq1.delete();
  endtask

  task automatic sb_drain(input int pct, input int budget, input string tag);
    bit pend[2];
    logic v[2], c[2];
    logic [31:0] d[2];
    logic [1:0] m[2];
    bit r[2];
    beat_t hd;
    int cyc, qs;
    pend[0] = 0; pend[1] = 0; cyc = 0;
    while (cyc < budget) begin
      @(negedge clk); cyc++;
      v[0] = mstr0_valid; v[1] = mstr1_valid; c[0] = mstr0_cmplt; c[1] = mstr1_cmplt;
      d[0] = mstr0_data;  d[1] = mstr1_data;  m[0] = mstr0_mode;  m[1] = mstr1_mode;
      n_chk++;
      if (v[0] === 1'b1 && v[1] === 1'b1) $display("FAIL %s both_valid: got 11 want at most one", tag);
      else n_pass++;
      for (int n = 0; n < 2; n++) begin
        n_chk++;
        if (c[n] !== logic'(pend[n])) $display("FAIL %s cmplt%0d: got %b want %b", tag, n, c[n], pend[n]);
        else n_pass++;
        qs = (n == 0) ? expq0.size() : expq1.size();
        if (v[n] !== 1'b1) begin
          n_chk++;
          if (v[n] !== 1'b0 || d[n] !== '0 || m[n] !== 2'b00)
            $display("FAIL %s idle%0d: got v=%b d=%h m=%b want 0/0/0", tag, n, v[n], d[n], m[n]);
          else n_pass++;
        end else begin
          n_chk++;
          if (qs == 0) $display("FAIL %s extra_beat%0d: got d=%h want no beat", tag, n, d[n]);
          else begin
            hd = (n == 0) ? expq0[0] : expq1[0];
            if (d[n] !== hd.data || m[n] !== hd.mode)
              $display("FAIL %s beat%0d: got %h/%b want %h/%b", tag, n, d[n], m[n], hd.data, hd.mode);
            else n_pass++;
          end
        end
      end
      r[0] = ($urandom_range(99) < pct); r[1] = ($urandom_range(99) < pct);
      rdy0 = r[0]; rdy1 = r[1];
      for (int n = 0; n < 2; n++) begin
        pend[n] = 0;
        qs = (n == 0) ? expq0.size() : expq1.size();
        if (v[n] === 1'b1 && r[n] && qs > 0) begin
          if (n == 0) hd = expq0.pop_front(); else hd = expq1.pop_front();
          pend[n] = hd.cm;
        end
      end
      if (expq0.size() == 0 && expq1.size() == 0 && fifo_empty && !pend[0] && !pend[1]) break;
    end
    n_chk++;
    if (cyc >= budget) $display("FAIL %s timeout: got %0d cycles want < %0d", tag, cyc, budget);
    else n_pass++;
    repeat (4) @(negedge clk);
    n_chk++;
    if (drop_cnt !== 8'((exp_drops > 255) ? 255 : exp_drops))
      $display("FAIL %s drop_cnt: got %0d want %0d", tag, drop_cnt, (exp_drops > 255) ? 255 : exp_drops);
    else n_pass++;
    rdy0 = 0; rdy1 = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy0 = 1'b1; rdy1 = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if (fifo_rd_en !== 1'b0 || mstr0_valid !== 1'b0 || mstr1_valid !== 1'b0 ||
        mstr0_cmplt !== 1'b0 || mstr1_cmplt !== 1'b0 || drop_cnt !== 8'd0)
      $display("FAIL reset_ctl: got rd=%b v=%b%b c=%b%b drop=%0d want all 0", fifo_rd_en,
               mstr1_valid, mstr0_valid, mstr1_cmplt, mstr0_cmplt, drop_cnt);
    else n_pass++;
    n_chk++;
    if (mstr0_data !== '0 || mstr1_data !== '0 || mstr0_mode !== 2'b00 || mstr1_mode !== 2'b00)
      $display("FAIL reset_data: got %h %h %b %b want 0", mstr0_data, mstr1_data, mstr0_mode, mstr1_mode);
    else n_pass++;
    rst = 1'b0; rdy0 = 1'b0; rdy1 = 1'b0;
    mcnt[0] = 0; mcnt[1] = 0; mlen[0] = 0; mlen[1] = 0; exp_drops = 0;
    @(negedge clk);
    n_chk++;
    if (fifo_rd_en !== 1'b0 || mstr0_valid !== 1'b0) $display("FAIL post_reset: got rd=%b v=%b want 0", fifo_rd_en, mstr0_valid);
    else n_pass++;
  endtask

  task automatic test_single_beat();
    rdy0 = 1'b1;
    push(1'b0, 2'b01, 8'd1, 32'hA5A5A5A5);
    @(negedge clk);
    n_chk++;
    if (fifo_rd_en !== 1'b1 || mstr0_valid !== 1'b0) $display("FAIL single_t1: got rd=%b v=%b want 1/0", fifo_rd_en, mstr0_valid);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (fifo_rd_en !== 1'b0 || mstr0_valid !== 1'b0) $display("FAIL single_t2: got rd=%b v=%b want 0/0", fifo_rd_en, mstr0_valid);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (mstr0_valid !== 1'b1 || mstr0_data !== 32'hA5A5A5A5 || mstr0_mode !== 2'b01 || mstr1_valid !== 1'b0)
      $display("FAIL single_t3: got v=%b d=%h m=%b v1=%b want 1/a5a5a5a5/01/0", mstr0_valid, mstr0_data, mstr0_mode, mstr1_valid);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (mstr0_cmplt !== 1'b1 || mstr0_valid !== 1'b0 || mstr1_cmplt !== 1'b0)
      $display("FAIL single_cmplt: got c0=%b v0=%b c1=%b want 1/0/0", mstr0_cmplt, mstr0_valid, mstr1_cmplt);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (mstr0_cmplt !== 1'b0) $display("FAIL single_pulse: got %b want 0", mstr0_cmplt);
    else n_pass++;
    rdy0 = 1'b0;
    model_clear();
  endtask

  task automatic test_backpressure();
    logic [31:0] d1, d2;
    int k;
    d1 = $urandom; d2 = $urandom;
    rdy0 = 1'b1; rdy1 = 1'b0;
    push(1'b1, 2'b10, 8'd1, d1);
    push(1'b1, 2'b10, 8'd1, d2);
    k = 0;
    while (mstr1_valid !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    n_chk++;
    if (k >= 20) $display("FAIL bp_wait: got no valid want valid within 20");
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_chk++;
      if (mstr1_valid !== 1'b1 || mstr1_data !== d1 || mstr1_mode !== 2'b10 || fifo_rd_en !== 1'b0 || mstr0_valid !== 1'b0)
        $display("FAIL bp_hold%0d: got v=%b d=%h m=%b rd=%b v0=%b want 1/%h/10/0/0", i,
                 mstr1_valid, mstr1_data, mstr1_mode, fifo_rd_en, mstr0_valid, d1);
      else n_pass++;
    end
    rdy1 = 1'b1;
    @(negedge clk);
    n_chk++;
    if (mstr1_cmplt !== 1'b1 || fifo_rd_en !== 1'b1 || mstr1_valid !== 1'b0)
      $display("FAIL bp_accept: got c=%b rd=%b v=%b want 1/1/0", mstr1_cmplt, fifo_rd_en, mstr1_valid);
    else n_pass++;
    k = 0;
    while (mstr1_valid !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    n_chk++;
    if (k >= 20 || mstr1_data !== d2) $display("FAIL bp_second: got %h want %h", mstr1_data, d2);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (mstr1_cmplt !== 1'b1) $display("FAIL bp_cmplt2: got %b want 1", mstr1_cmplt);
    else n_pass++;
    rdy0 = 1'b0; rdy1 = 1'b0;
    model_clear();
  endtask

  task automatic test_procval0();
    int k;
    rdy0 = 1'b1;
    push(1'b0, 2'b11, 8'd0, 32'h0BADF00D);
    k = 0;
    while (mstr0_valid !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    n_chk++;
    if (k >= 20 || mstr0_data !== 32'h0BADF00D || mstr0_mode !== 2'b11)
      $display("FAIL pv0_beat: got %h/%b want 0badf00d/11", mstr0_data, mstr0_mode);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (mstr0_cmplt !== 1'b1) $display("FAIL pv0_cmplt: got %b want 1", mstr0_cmplt);
    else n_pass++;
    rdy0 = 1'b0;
    model_clear();
  endtask

  task automatic test_interleave();
    model_clear();
    push(1'b0, 2'b01, 8'd3, 32'h00000001);
    push(1'b1, 2'b01, 8'd2, 32'h10000001);
    push(1'b0, 2'b10, 8'd7, 32'h00000002);
    push(1'b1, 2'b11, 8'd9, 32'h10000002);
    push(1'b0, 2'b01, 8'd5, 32'h00000003);
    sb_drain(100, 200, "interleave");
  endtask

  task automatic test_drop();
    model_clear();
    for (int i = 0; i < 300; i++) push(1'($urandom_range(1)), 2'b00, 8'($urandom), $urandom);
    sb_drain(100, 1500, "drop");
    n_chk++;
    if (drop_cnt !== 8'd255) $display("FAIL drop_sat: got %0d want 255", drop_cnt);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [1:0] m;
    model_clear();
    for (int i = 0; i < 150; i++) begin
      m = ($urandom_range(3) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      push(1'($urandom_range(1)), m, 8'($urandom_range(4)), $urandom);
    end
    sb_drain(60, 3000, "random");
  endtask

  task automatic test_reset_in_send();
    int k;
    model_clear();
    rdy1 = 1'b1;
    push(1'b1, 2'b01, 8'd3, 32'h11111111);
    push(1'b1, 2'b01, 8'd3, 32'h22222222);
    k = 0;
    while (mstr1_valid !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    @(negedge clk);
    rdy1 = 1'b0;
    k = 0;
    while (mstr1_valid !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    n_chk++;
    if (k >= 20 || mstr1_data !== 32'h22222222) $display("FAIL rs_setup: got %h want 22222222", mstr1_data);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if (mstr1_valid !== 1'b0 || mstr1_data !== '0 || mstr1_mode !== 2'b00 || fifo_rd_en !== 1'b0 ||
        mstr1_cmplt !== 1'b0 || mstr0_valid !== 1'b0 || drop_cnt !== 8'd0)
      $display("FAIL rs_clear: got v=%b d=%h rd=%b c=%b drop=%0d want all 0", mstr1_valid, mstr1_data,
               fifo_rd_en, mstr1_cmplt, drop_cnt);
    else n_pass++;
    rst = 1'b0; rdy1 = 1'b1;
    mcnt[0] = 0; mcnt[1] = 0; exp_drops = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_chk++;
      if (mstr1_valid !== 1'b0 || mstr1_cmplt !== 1'b0) $display("FAIL rs_replay%0d: got v=%b c=%b want 0/0", i, mstr1_valid, mstr1_cmplt);
      else n_pass++;
    end
    push(1'b1, 2'b01, 8'd1, 32'h33333333);
    k = 0;
    while (mstr1_valid !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    @(negedge clk);
    n_chk++;
    if (mstr1_cmplt !== 1'b1) $display("FAIL rs_counter: got cmplt %b want 1", mstr1_cmplt);
    else n_pass++;
    rdy1 = 1'b0;
    model_clear();
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_backpressure();
    test_procval0();
    test_interleave();
    test_drop();
    test_random();
    test_reset_in_send();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
